// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: opcode class codes
// (instruction[6:2], same values ImmGen decodes), the NOP word, immediate
// field widths, the request payload, and range-check helpers.
package inst_encoder_pkg;

  // Opcode class codes, instruction[6:2]
  localparam logic [4:0] OPC_LOAD    = 5'b00000;
  localparam logic [4:0] OPC_ARITH_I = 5'b00100;
  localparam logic [4:0] OPC_AUIPC   = 5'b00101;
  localparam logic [4:0] OPC_STORE   = 5'b01000;
  localparam logic [4:0] OPC_ARITH_R = 5'b01100;
  localparam logic [4:0] OPC_LUI     = 5'b01101;
  localparam logic [4:0] OPC_BRANCH  = 5'b11000;
  localparam logic [4:0] OPC_JALR    = 5'b11001;
  localparam logic [4:0] OPC_JAL     = 5'b11011;

  // funct3 codes that turn ARITH_I into a shift-by-immediate
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Signed field widths (including sign bit) and shift-amount width
  localparam int unsigned IMM_I_W = 12;
  localparam int unsigned IMM_S_W = 12;
  localparam int unsigned IMM_B_W = 13;
  localparam int unsigned IMM_J_W = 21;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned U_LOW_W = 12;

  // Decoded request as captured in stage 1
  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_req_t;

  // True when the immediate is a shift amount rather than a signed value
  function automatic logic is_shift(input logic [4:0] opcode, input logic [2:0] funct3);
    return (opcode == OPC_ARITH_I) && ((funct3 == F3_SLL) || (funct3 == F3_SRX));
  endfunction

  // All bits above the field's sign bit must replicate it
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned width);
    logic [31:0] hi;
    hi = 32'($signed(imm) >>> (width - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_imm_range_check.sv
// Combinational immediate legality check for one request.
// Ports: i_opcode (instr[6:2] class), i_funct3, i_imm (signed immediate),
//        o_legal_c (1 = request encodable without loss).
module inst_encoder_imm_range_check
  import inst_encoder_pkg::*;
(
  input  logic [4:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_imm,
  output logic        o_legal_c
);

  // Per-format range and alignment rules
  always_comb begin
    o_legal_c = 1'b0;
    case (i_opcode)
      OPC_ARITH_R: o_legal_c = 1'b1;
      OPC_ARITH_I: begin
        if (is_shift(i_opcode, i_funct3)) o_legal_c = (i_imm[31:SHAMT_W] == '0);
        else                              o_legal_c = fits_signed(i_imm, IMM_I_W);
      end
      OPC_LOAD, OPC_JALR: o_legal_c = fits_signed(i_imm, IMM_I_W);
      OPC_STORE:          o_legal_c = fits_signed(i_imm, IMM_S_W);
      OPC_BRANCH:         o_legal_c = fits_signed(i_imm, IMM_B_W) && !i_imm[0];
      OPC_JAL:            o_legal_c = fits_signed(i_imm, IMM_J_W) && !i_imm[0];
      OPC_LUI, OPC_AUIPC: o_legal_c = (i_imm[U_LOW_W-1:0] == '0);
      default:            o_legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: inverse of ImmGen. Two-stage valid/ready pipe
// (S1 = request + legality, S2 = assembled word), word address counter and
// saturating error counter.
// Ports: clk, rst_n (sync, active-low), clear (reload address);
//        in_* request handshake and fields; out_valid/out_ready handshake,
//        out_inst, out_addr, out_err; err_count (saturating, 8 bit).
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  localparam logic [7:0] ERR_MAX = 8'hFF;

  enc_req_t          w_req;
  logic              w_legal;
  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              w_out_fire;
  logic [6:0]        w_op;
  logic [31:0]       w_inst;

  logic              r_s1_valid;
  enc_req_t          r_s1_req;
  logic              r_s1_legal;
  logic              r_out_valid;
  logic [31:0]       r_out_inst;
  logic              r_out_err;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_err_count;

  assign w_req = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                   funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  // Legality is evaluated on the incoming request and captured with it in S1
  inst_encoder_imm_range_check u_imm_range_check (
    .i_opcode  (in_opcode),
    .i_funct3  (in_funct3),
    .i_imm     (in_imm),
    .o_legal_c (w_legal)
  );

  // A stage loads when it is empty or its contents leave this cycle
  assign w_s2_adv   = !r_out_valid || out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_out_fire = r_out_valid && out_ready;
  assign in_ready   = w_s1_adv;

  // Scatter S1 fields into the instruction word; illegal requests become NOP
  always_comb begin
    w_op   = {r_s1_req.opcode, 2'b11};
    w_inst = NOP_INST;
    case (r_s1_req.opcode)
      OPC_ARITH_R:
        w_inst = {r_s1_req.funct7, r_s1_req.rs2, r_s1_req.rs1, r_s1_req.funct3, r_s1_req.rd, w_op};
      OPC_ARITH_I: begin
        if (is_shift(r_s1_req.opcode, r_s1_req.funct3))
          w_inst = {r_s1_req.funct7, r_s1_req.imm[4:0], r_s1_req.rs1, r_s1_req.funct3,
                    r_s1_req.rd, w_op};
        else
          w_inst = {r_s1_req.imm[11:0], r_s1_req.rs1, r_s1_req.funct3, r_s1_req.rd, w_op};
      end
      OPC_LOAD, OPC_JALR:
        w_inst = {r_s1_req.imm[11:0], r_s1_req.rs1, r_s1_req.funct3, r_s1_req.rd, w_op};
      OPC_STORE:
        w_inst = {r_s1_req.imm[11:5], r_s1_req.rs2, r_s1_req.rs1, r_s1_req.funct3,
                  r_s1_req.imm[4:0], w_op};
      OPC_BRANCH:
        w_inst = {r_s1_req.imm[12], r_s1_req.imm[10:5], r_s1_req.rs2, r_s1_req.rs1,
                  r_s1_req.funct3, r_s1_req.imm[4:1], r_s1_req.imm[11], w_op};
      OPC_JAL:
        w_inst = {r_s1_req.imm[20], r_s1_req.imm[10:1], r_s1_req.imm[11], r_s1_req.imm[19:12],
                  r_s1_req.rd, w_op};
      OPC_LUI, OPC_AUIPC:
        w_inst = {r_s1_req.imm[31:12], r_s1_req.rd, w_op};
      default: w_inst = NOP_INST;
    endcase
    if (!r_s1_legal) w_inst = NOP_INST;
  end

  // Stage 1: request capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_req   <= '0;
      r_s1_legal <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_req   <= w_req;
        r_s1_legal <= w_legal;
      end
    end
  end

  // Stage 2: assembled word, held while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_inst <= w_inst;
        r_out_err  <= !r_s1_legal;
      end
    end
  end

  // Address and error counters; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr      <= ADDR_W'(BASE_ADDR);
      r_err_count <= '0;
    end else begin
      if (clear)           r_addr <= ADDR_W'(BASE_ADDR);
      else if (w_out_fire) r_addr <= r_addr + ADDR_W'(1);
      if (w_out_fire && r_out_err && (r_err_count != ERR_MAX))
        r_err_count <= r_err_count + 8'd1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_inst  = r_out_inst;
  assign out_err   = r_out_err;
  assign out_addr  = r_addr;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: stimulus pushes expected words,
// a negedge monitor pops and compares on every transfer.
module tb_inst_encoder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned BASE   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, clear, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [4:0]        in_opcode, in_rd, in_rs1, in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm, out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0]        err_count;

  logic man_rdy, man_clr, rnd_bp, rnd_rdy, rnd_clr;
  assign out_ready = rnd_bp ? rnd_rdy : man_rdy;
  assign clear     = man_clr | (rnd_bp & rnd_clr);

  inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  typedef struct {
    logic [4:0] op; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    logic [2:0] f3; logic [6:0] f7; logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] inst; logic err; logic rt; logic [4:0] op; logic [31:0] imm;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int m_addr = BASE;
  int m_err  = 0;
  int cyc    = 0;
  int bnd[16] = '{-4097, -4096, -2049, -2048, -1, 0, 31, 32, 2047, 2048,
                  4094, 4095, 1048574, 1048576, -1048576, -1048578};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    rnd_rdy <= ($urandom_range(0, 3) != 0);
    rnd_clr <= ($urandom_range(0, 63) == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoder: field placement and range rules in plain arithmetic
  function automatic exp_t model(input req_t r);
    exp_t e;
    int s;
    logic [31:0] u, opc, rdf, rs1f, rs2f, f3f, f7f, w;
    logic ok;
    s = $signed(r.imm);
    u = r.imm;
    opc  = (32'(r.op) << 2) | 32'd3;
    rdf  = 32'(r.rd) << 7;
    rs1f = 32'(r.rs1) << 15;
    rs2f = 32'(r.rs2) << 20;
    f3f  = 32'(r.f3) << 12;
    f7f  = 32'(r.f7) << 25;
    ok = 1'b0; w = 32'h0; e.rt = 1'b1;
    case (r.op)
      5'b01100: begin ok = 1'b1; e.rt = 1'b0; w = f7f | rs2f | rs1f | f3f | rdf | opc; end
      5'b00100, 5'b00000, 5'b11001: begin
        if (r.op == 5'b00100 && (r.f3 == 3'd1 || r.f3 == 3'd5)) begin
          ok = (s >= 0) && (s <= 31); e.rt = 1'b0;
          w = f7f | ((u & 32'h1F) << 20) | rs1f | f3f | rdf | opc;
        end else begin
          ok = (s >= -2048) && (s <= 2047);
          w = ((u & 32'hFFF) << 20) | rs1f | f3f | rdf | opc;
        end
      end
      5'b01000: begin
        ok = (s >= -2048) && (s <= 2047);
        w = (((u >> 5) & 32'h7F) << 25) | rs2f | rs1f | f3f | ((u & 32'h1F) << 7) | opc;
      end
      5'b11000: begin
        ok = (s >= -4096) && (s <= 4094) && !u[0];
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | rs2f | rs1f | f3f |
            (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | opc;
      end
      5'b11011: begin
        ok = (s >= -1048576) && (s <= 1048574) && !u[0];
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20) |
            (((u >> 12) & 32'hFF) << 12) | rdf | opc;
      end
      5'b01101, 5'b00101: begin
        ok = ((u & 32'hFFF) == 0);
        w = (u & 32'hFFFFF000) | rdf | opc;
      end
      default: ok = 1'b0;
    endcase
    e.inst = ok ? w : 32'h00000013;
    e.err  = !ok;
    e.rt   = e.rt && ok;
    e.op   = r.op;
    e.imm  = r.imm;
    return e;
  endfunction

  // ImmGen view of an encoded word, used for the round-trip check
  function automatic logic [31:0] immgen(input logic [4:0] op, input logic [31:0] i);
    case (op)
      5'b01000:           return {{20{i[31]}}, i[31:25], i[11:7]};
      5'b11000:           return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      5'b11011:           return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      5'b01101, 5'b00101: return {i[31:12], 12'b0};
      default:            return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  function automatic req_t mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input int imm);
    req_t r;
    r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7 = f7; r.imm = 32'(imm);
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    case ($urandom_range(0, 9))
      0: r.op = 5'b01100; 1: r.op = 5'b00100; 2: r.op = 5'b00000; 3: r.op = 5'b11001;
      4: r.op = 5'b01000; 5: r.op = 5'b11000; 6: r.op = 5'b11011; 7: r.op = 5'b01101;
      8: r.op = 5'b00101; default: r.op = 5'($urandom_range(0, 31));
    endcase
    r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
    r.f3 = 3'($urandom); r.f7 = 7'($urandom);
    case ($urandom_range(0, 4))
      0: r.imm = 32'(int'($urandom_range(0, 8191)) - 4096);
      1: r.imm = 32'(bnd[$urandom_range(0, 15)]);
      2: r.imm = $urandom();
      3: r.imm = $urandom() & 32'hFFFFF000;
      default: r.imm = 32'($urandom_range(0, 40));
    endcase
    return r;
  endfunction

  // Monitor: compare every transfer; track the address and error counters
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      m_addr = BASE;
      m_err  = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_word", out_inst, 32'hxxxxxxxx);
        end else begin
          e = q.pop_front();
          chk("inst", out_inst, e.inst);
          chk("err", 32'(out_err), 32'(e.err));
          chk("addr", 32'(out_addr), 32'(m_addr));
          if (e.rt) chk("roundtrip", immgen(e.op, out_inst), e.imm);
          if (e.err && m_err < 255) m_err = m_err + 1;
        end
        m_addr = clear ? BASE : (m_addr + 1) % (1 << ADDR_W);
      end else if (clear) begin
        m_addr = BASE;
      end
    end
  end

  // Drive one request (starting just after a posedge) and hold it until accepted
  task automatic send(input req_t r, input logic use_lit, input logic [31:0] lit_inst,
                      input logic lit_err);
    exp_t e;
    logic acc;
    e = model(r);
    if (use_lit) begin e.inst = lit_inst; e.err = lit_err; end
    in_valid = 1'b1; in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
    in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm;
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready && rst_n;
      if (acc) q.push_back(e);
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      done = (q.size() == 0) && !out_valid;
    end
    chk("drain", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int c0;
    req_t ra, rb, rc;
    rst_n = 1'b0; man_rdy = 1'b1; man_clr = 1'b0; rnd_bp = 1'b0;
    in_valid = 1'b0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'(BASE));
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // addi x1, x0, 5 with latency check
    send(mk(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 5), 1'b1, 32'h00500093, 1'b0);
    @(negedge clk); chk("lat_s1", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_s2", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Back-to-back directed words, one accept per cycle
    c0 = cyc;
    send(mk(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 8),          1'b1, 32'h00208463, 1'b0);
    send(mk(5'b01000, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, -4),         1'b1, 32'hFE20AE23, 1'b0);
    send(mk(5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 16),         1'b1, 32'h010000EF, 1'b0);
    send(mk(5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 'h12345000), 1'b1, 32'h123452B7, 1'b0);
    chk("throughput", 32'(cyc - c0), 32'd4);
    drain();

    // Illegal requests
    send(mk(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 4096), 1'b1, 32'h00000013, 1'b1);
    send(mk(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 7),    1'b1, 32'h00000013, 1'b1);
    drain();
    chk("err_count_2", 32'(err_count), 32'd2);

    // Backpressure: two accepted, third blocked, outputs held
    man_rdy = 1'b0;
    ra = mk(5'b00000, 5'd3, 5'd4, 5'd0, 3'd2, 7'd0, -2048);
    rb = mk(5'b01100, 5'd7, 5'd8, 5'd9, 3'd5, 7'h20, 0);
    rc = mk(5'b11001, 5'd1, 5'd6, 5'd0, 3'd0, 7'd0, 2047);
    send(ra, 1'b0, 32'd0, 1'b0);
    send(rb, 1'b0, 32'd0, 1'b0);
    in_valid = 1'b1; in_opcode = rc.op; in_imm = rc.imm;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_inst", out_inst, q[0].inst);
      @(posedge clk); #1;
    end
    man_rdy = 1'b1;
    send(rc, 1'b0, 32'd0, 1'b0);
    drain();

    // Clear coinciding with a transfer: word keeps pre-clear address
    man_rdy = 1'b0;
    send(mk(5'b00100, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, -1), 1'b0, 32'd0, 1'b0);
    send(mk(5'b00101, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 'h7FFFF000), 1'b0, 32'd0, 1'b0);
    man_clr = 1'b1; man_rdy = 1'b1;
    @(negedge clk); chk("clr_pre_addr", 32'(out_addr), 32'd10);
    @(posedge clk); #1;
    man_clr = 1'b0;
    @(negedge clk); chk("clr_base_addr", 32'(out_addr), 32'(BASE));
    @(posedge clk); #1;
    drain();

    // Randomized traffic with random backpressure and occasional clear
    rnd_bp = 1'b1;
    for (int i = 0; i < 400; i++) send(rnd_req(), 1'b0, 32'd0, 1'b0);
    rnd_bp = 1'b0;
    drain();

    // Saturation of the error counter
    for (int i = 0; i < 300; i++)
      send(mk(5'b11111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0), 1'b0, 32'd0, 1'b0);
    drain();
    chk("err_count_sat", 32'(err_count), 32'd255);

    // Reset with both stages full
    man_rdy = 1'b0;
    send(mk(5'b00100, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 1), 1'b0, 32'd0, 1'b0);
    send(mk(5'b11110, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 1), 1'b0, 32'd0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_addr", 32'(out_addr), 32'(BASE));
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    man_rdy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(mk(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 5), 1'b1, 32'h00500093, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
